i2c_init_seq: RTL and testbench
===============================

Name: i2c_init_seq

Overview:
- Parametrised power-up register-initialisation sequencer for I2C peripherals (OLED, sensors, codecs).
- Walks a command table in an external synchronous ROM and issues one I2C register write per entry through the existing I2C master handshake (write_i2c_en / i2c_done).
- Adds over the previous generation:
  - configurable table depth and delay;
  - per-entry register address taken from the table;
  - NACK retry and an error exit.

Parameters:
- CMD_NUM, 28: number of table entries executed (1..2**ROM_AW).
- ROM_AW, 5: ROM address width.
- DELAY_CYCLES, 50000: inter-command settle time in clk cycles (>=1).
- CNT_W, 16: delay counter width; must satisfy 2**CNT_W > DELAY_CYCLES.
- MAX_RETRY, 3: re-attempts per entry after a NACK before aborting (0 = no retry).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin sequence; sampled only in IDLE
- rom_en  out  1  ROM read enable
- rom_addr  out  ROM_AW  ROM entry index
- rom_data  in  16  entry data, valid 1 cycle after rom_en; [15:8] register address, [7:0] register data
- reg_addr  out  8  register address to I2C master, held stable from issue until i2c_done
- reg_data  out  8  register data to I2C master, held as reg_addr
- write_i2c_en  out  1  single-cycle write request
- i2c_done  in  1  single-cycle transfer-complete pulse
- i2c_nack  in  1  qualifies i2c_done: 1 = transfer NACKed
- busy  out  1  high from start acceptance until done or error pulse
- done  out  1  single-cycle pulse, sequence completed
- error  out  1  single-cycle pulse, sequence aborted
- cmd_idx  out  ROM_AW  current entry index (debug)

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-low. On reset, state goes to IDLE and every output is 0: rom_en, rom_addr, reg_addr, reg_data, write_i2c_en, busy, done, error, cmd_idx. The retry count and delay counter are also cleared. Reset mid-sequence aborts immediately, with no done or error pulse.
- IDLE: when start=1, assert rom_en with rom_addr=cmd_idx=0, set busy=1, go to FETCH.
- FETCH (1 cycle): capture rom_data into reg_addr/reg_data, go to ISSUE.
- ISSUE (1 cycle): write_i2c_en=1, go to WAIT_I2C. Latency from start to write_i2c_en is 2 cycles.
- WAIT_I2C: wait with no timeout until i2c_done.
  - i2c_nack=0: clear the retry count, go to SLEEP.
  - i2c_nack=1 and retry count < MAX_RETRY: increment the retry count, go to SLEEP. The same entry is re-issued afterwards.
  - i2c_nack=1 and retry count = MAX_RETRY: go to ERROR.
- SLEEP: the delay counter runs 0..DELAY_CYCLES-1, so SLEEP lasts exactly DELAY_CYCLES cycles. On exit:
  - Retry pending: re-issue the entry. Assert rom_en at the same index, go to FETCH.
  - Entry succeeded and cmd_idx = CMD_NUM-1: go to DONE.
  - Entry succeeded otherwise: cmd_idx+1, assert rom_en at the new index, go to FETCH.
  - The delay also applies after the final entry.
- DONE (1 cycle): done=1, busy=0 next cycle, cmd_idx=0, return to IDLE.
- ERROR (1 cycle): error=1, busy=0 next cycle, cmd_idx holds the failing index until the next start, return to IDLE.
- Boundary conditions:
  - start while busy: ignored.
  - start asserted the same cycle the DONE/ERROR pulse is asserted: ignored. Accepted from the following IDLE cycle.
  - i2c_done outside WAIT_I2C: ignored.
  - rom_en is asserted exactly one cycle per fetch.
  - rom_addr equals cmd_idx at all times.

Optional Feature:
- Macro: INIT_SEQ_DELAY_CMD_EN.
- Defined: an entry with rom_data[15:8]=8'hFF is a delay pseudo-command. No I2C write is issued. The block stays in SLEEP for rom_data[7:0] x DELAY_CYCLES cycles; a value of 0 gives exactly DELAY_CYCLES. The normal inter-command delay is not added on top. Then it advances as a successful entry.
- Undefined: 8'hFF is an ordinary register address.

Decomposition:
- Shared package i2c_init_pkg holds:
  - the state encoding: IDLE, FETCH, ISSUE, WAIT_I2C, SLEEP, DONE, ERROR;
  - the entry field positions (ENTRY_ADDR_MSB/LSB, ENTRY_DATA_MSB/LSB);
  - the DELAY_CMD_ADDR=8'hFF constant.
- One sub-module is natural: init_delay_cnt, a loadable down-counter with a terminal pulse used by SLEEP. The ROM stays outside the block.

Test Plan:
- CMD_NUM=4, DELAY_CYCLES=10, I2C model acks after 5 cycles, start pulse:
  - 4 writes in ROM order with reg_addr/reg_data matching the table;
  - write_i2c_en 2 cycles after start;
  - 10 idle cycles between each i2c_done and the next rom_en;
  - one done pulse; busy falls with it.
- NACK on entry 2 twice, then ack, MAX_RETRY=3: entry 2 is written 3 times; the sequence completes with done and no error.
- NACK on entry 1 four times, MAX_RETRY=3: 4 attempts, then an error pulse with cmd_idx=1. No entry-2 fetch and no done.
- Reset held low for 1 cycle mid-SLEEP of entry 2: all outputs 0 next cycle, no done/error pulse. A fresh start restarts from entry 0.
- start re-pulsed during WAIT_I2C, and again coincident with done: no effect, one sequence only. A start 1 cycle after done launches a new sequence.
- With INIT_SEQ_DELAY_CMD_EN, entry {8'hFF, 8'd3}, DELAY_CYCLES=10: no write_i2c_en for that entry; 30-cycle gap before the next fetch.

Source files
------------

// File: rtl/i2c_init_pkg.sv
// rtl/i2c_init_pkg.sv - shared state encoding and command-table entry layout for i2c_init_seq
package i2c_init_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_I2C,
        SLEEP,
        DONE,
        ERROR
    } state_t;

    localparam int ENTRY_ADDR_MSB = 15;
    localparam int ENTRY_ADDR_LSB = 8;
    localparam int ENTRY_DATA_MSB = 7;
    localparam int ENTRY_DATA_LSB = 0;

    localparam logic [7:0] DELAY_CMD_ADDR = 8'hFF;

endpackage

// File: rtl/init_delay_cnt.sv
// rtl/init_delay_cnt.sv - loadable down-counter with a one-cycle terminal pulse
module init_delay_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;
    logic             active;

    // Loading N-1 yields tc on the N-th cycle after the load edge; reload wins over expiry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign tc = active && (count == '0);

endmodule

// File: rtl/i2c_init_seq.sv
// rtl/i2c_init_seq.sv - I2C register-init sequencer; INIT_SEQ_DELAY_CMD_EN enables 8'hFF delay entries
module i2c_init_seq
    import i2c_init_pkg::*;
#(
    parameter int CMD_NUM      = 28,
    parameter int ROM_AW       = 5,
    parameter int DELAY_CYCLES = 50000,
    parameter int CNT_W        = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        reg_addr,
    output logic [7:0]        reg_data,
    output logic              write_i2c_en,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] cmd_idx
);

    localparam int                RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(CMD_NUM - 1);
    localparam logic [CNT_W-1:0]  DLY_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);

    state_t            state, next_state;
    logic [ROM_AW-1:0] idx_q, fetch_idx;
    logic [RW-1:0]     retry_cnt;
    logic [7:0]        periods;
    logic [7:0]        ent_addr, ent_data;
    logic              tc, sleep_end, retry_pend, is_delay_cmd, dly_load, rom_req;

    assign ent_addr = rom_data[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
    assign ent_data = rom_data[ENTRY_DATA_MSB:ENTRY_DATA_LSB];

`ifdef INIT_SEQ_DELAY_CMD_EN
    assign is_delay_cmd = (ent_addr == DELAY_CMD_ADDR);
`else
    assign is_delay_cmd = 1'b0;
`endif

    // A nonzero retry count at SLEEP exit means the last attempt was NACKed.
    assign retry_pend = (retry_cnt != '0);
    assign sleep_end  = (state == SLEEP) && tc && (periods == 8'd1);
    assign dly_load   = ((next_state == SLEEP) && (state != SLEEP))
                      || ((state == SLEEP) && tc && (periods != 8'd1));

    init_delay_cnt #(.CNT_W(CNT_W)) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (dly_load),
        .load_val (DLY_LOAD),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = FETCH;
            FETCH:    next_state = is_delay_cmd ? SLEEP : ISSUE;
            ISSUE:    next_state = WAIT_I2C;
            WAIT_I2C: begin
                if (i2c_done) begin
                    if (i2c_nack && (retry_cnt == RETRY_MAX)) begin
                        next_state = ERROR;
                    end else begin
                        next_state = SLEEP;
                    end
                end
            end
            SLEEP: begin
                if (sleep_end) begin
                    next_state = (!retry_pend && (idx_q == LAST_IDX)) ? DONE : FETCH;
                end
            end
            DONE:     next_state = IDLE;
            ERROR:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // rom_en and the index it addresses are combinational so the ROM word arrives in FETCH.
    always_comb begin
        rom_req      = 1'b0;
        fetch_idx    = idx_q;
        write_i2c_en = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    rom_req   = 1'b1;
                    fetch_idx = '0;
                end
            end
            SLEEP: begin
                if (sleep_end && (retry_pend || (idx_q != LAST_IDX))) begin
                    rom_req   = 1'b1;
                    fetch_idx = retry_pend ? idx_q : idx_q + 1'b1;
                end
            end
            ISSUE:   write_i2c_en = 1'b1;
            DONE:    done = 1'b1;
            ERROR:   error = 1'b1;
            default: ;
        endcase
        rom_en   = rom_req && reset;
        cmd_idx  = rom_en ? fetch_idx : idx_q;
        rom_addr = cmd_idx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q     <= '0;
            retry_cnt <= '0;
            periods   <= '0;
            reg_addr  <= '0;
            reg_data  <= '0;
        end else begin
            if (rom_en) begin
                idx_q <= fetch_idx;
            end else if ((state == SLEEP) && (next_state == DONE)) begin
                idx_q <= '0;
            end

            if ((state == IDLE) && start) begin
                retry_cnt <= '0;
            end else if ((state == WAIT_I2C) && i2c_done) begin
                if (!i2c_nack) begin
                    retry_cnt <= '0;
                end else if (retry_cnt < RETRY_MAX) begin
                    retry_cnt <= retry_cnt + 1'b1;
                end
            end

            if ((state == FETCH) && is_delay_cmd) begin
                periods <= (ent_data == 8'd0) ? 8'd1 : ent_data;
            end else if ((state == WAIT_I2C) && i2c_done) begin
                periods <= 8'd1;
            end else if ((state == SLEEP) && tc && (periods != 8'd1)) begin
                periods <= periods - 1'b1;
            end

            if (state == FETCH) begin
                reg_addr <= ent_addr;
                reg_data <= ent_data;
            end
        end
    end

endmodule

// File: tb/tb_i2c_init_seq.sv
// tb/tb_i2c_init_seq.sv - scoreboard bench for i2c_init_seq with a cycle-level reference model
module tb_i2c_init_seq;

    localparam int CMD_NUM   = 4;
    localparam int ROM_AW    = 5;
    localparam int DELAY     = 10;
    localparam int CNT_W     = 16;
    localparam int MAX_RETRY = 3;
    localparam int I2C_LAT   = 5;

    localparam int K_FETCH = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERROR = 3;

    typedef struct {
        int          kind;
        int          cyc;
        int          idx;
        logic [15:0] ent;
    } ev_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [7:0]        reg_addr;
    logic [7:0]        reg_data;
    logic              write_i2c_en;
    logic              i2c_done;
    logic              i2c_nack;
    logic              busy;
    logic              done;
    logic              error;
    logic [ROM_AW-1:0] cmd_idx;

    logic [15:0] rom [0:(1<<ROM_AW)-1];
    logic [15:0] rom_q = '0;
    ev_t         exp_q[$];
    bit          nack_q[$];
    int          plan [CMD_NUM];
    int          cyc = 0;
    int          issue_cyc = -100;
    bit          nack_cur = 1'b0;
    bit          fin = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    i2c_init_seq #(
        .CMD_NUM(CMD_NUM), .ROM_AW(ROM_AW), .DELAY_CYCLES(DELAY),
        .CNT_W(CNT_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .reg_addr(reg_addr), .reg_data(reg_data),
        .write_i2c_en(write_i2c_en), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .busy(busy), .done(done), .error(error), .cmd_idx(cmd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rom_en) rom_q <= rom[rom_addr];
    end
    assign rom_data = rom_q;

    // I2C master stand-in: completes each write I2C_LAT cycles after the request.
    initial begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i2c_done = (cyc == issue_cyc + I2C_LAT);
            i2c_nack = i2c_done && nack_cur;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        bit   rst_seen;
        bit   after_end;
        int   kind;
        ev_t  e;
        rst_seen  = 1'b1;
        after_end = 1'b0;
        forever begin
            @(negedge clk);
            if (fin) begin
                chk("leftover_events", exp_q.size(), 0);
                chk("leftover_nacks", nack_q.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
            if (!rst_seen) begin
                chk("reset_outputs", int'({rom_en, rom_addr, reg_addr, reg_data, write_i2c_en,
                                           busy, done, error, cmd_idx}), 0);
            end
            rst_seen = reset;
            if (reset) begin
                chk("rom_addr_vs_cmd_idx", int'(rom_addr), int'(cmd_idx));
                if (after_end) chk("busy_after_pulse", int'(busy), 0);
                after_end = done || error;
                kind = rom_en ? K_FETCH : write_i2c_en ? K_WRITE : done ? K_DONE : error ? K_ERROR : -1;
                if (kind >= 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", kind, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", kind, e.kind);
                        chk("event_cycle", cyc, e.cyc);
                        chk("cmd_idx", int'(cmd_idx), e.idx);
                        chk("busy_in_event", int'(busy), (kind == K_FETCH) ? int'(busy) : 1);
                        if (kind == K_WRITE) begin
                            chk("reg_addr", int'(reg_addr), int'(e.ent[15:8]));
                            chk("reg_data", int'(reg_data), int'(e.ent[7:0]));
                        end
                    end
                    if (kind == K_WRITE) begin
                        issue_cyc = cyc;
                        if (nack_q.size() == 0) begin
                            chk("unplanned_write", 1, 0);
                            nack_cur = 1'b0;
                        end else begin
                            nack_cur = nack_q.pop_front();
                        end
                    end
                end
            end
        end
    end

    // Reference model: expected event timeline from the sequencing rules.
    task automatic model(input int s, output int e);
        int          r;
        int          n;
        bit          nk;
        logic [15:0] ent;
        r = s;
        e = s;
        for (int i = 0; i < CMD_NUM; i++) begin
            ent = rom[i];
`ifdef INIT_SEQ_DELAY_CMD_EN
            if (ent[15:8] == 8'hFF) begin
                n = (ent[7:0] == 8'd0) ? 1 : int'(ent[7:0]);
                exp_q.push_back('{K_FETCH, r, i, ent});
                if (i == CMD_NUM - 1) begin
                    e = r + 2 + n * DELAY;
                    exp_q.push_back('{K_DONE, e, 0, ent});
                    return;
                end
                r = r + 1 + n * DELAY;
                continue;
            end
`endif
            for (int a = 0; a <= MAX_RETRY; a++) begin
                exp_q.push_back('{K_FETCH, r, i, ent});
                exp_q.push_back('{K_WRITE, r + 2, i, ent});
                nk = (a < plan[i]);
                nack_q.push_back(nk);
                if (nk && (a == MAX_RETRY)) begin
                    e = r + 3 + I2C_LAT;
                    exp_q.push_back('{K_ERROR, e, i, ent});
                    return;
                end
                if (!nk && (i == CMD_NUM - 1)) begin
                    e = r + 3 + I2C_LAT + DELAY;
                    exp_q.push_back('{K_DONE, e, 0, ent});
                    return;
                end
                r = r + 2 + I2C_LAT + DELAY;
                if (!nk) break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic fill_rom(input bit special);
        for (int i = 0; i < (1 << ROM_AW); i++) begin
            rom[i] = 16'($urandom);
`ifdef INIT_SEQ_DELAY_CMD_EN
            if (rom[i][15:8] == 8'hFF) rom[i][15:8] = 8'hFE;
        end
        if (special) rom[1] = 16'hFF03;
`else
        end
        if (special) rom[3][15:8] = 8'hFF;
`endif
    endtask

    task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
        plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
    endtask

    task automatic run_seq(input int s, output int e);
        model(s, e);
        goto(s);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int s;
        int e;
        int e2;
        reset = 1'b0;
        start = 1'b0;
        fill_rom(1'b1);
        repeat (3) step();
        reset = 1'b1;

        set_plan(0, 0, 0, 0);
        run_seq(cyc + 2, e);
        goto(e + 3);

        fill_rom(1'b0);
        set_plan(0, 0, 2, 0);
        run_seq(cyc + 2, e);
        goto(e + 3);

        set_plan(0, 4, 0, 0);
        run_seq(cyc + 2, e);
        goto(e + 3);

        // Reset in the middle of entry 2's settle period, then a fresh sequence.
        set_plan(0, 0, 0, 0);
        s = cyc + 2;
        run_seq(s, e);
        goto(s + 2 * (2 + I2C_LAT + DELAY) + 2 + I2C_LAT + 5);
        reset = 1'b0;
        exp_q.delete();
        nack_q.delete();
        step();
        reset = 1'b1;
        goto(cyc + 3);
        set_plan($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        run_seq(cyc + 2, e);
        goto(e + 3);

        // start while busy and coincident with done is ignored; the next cycle's start is taken.
        set_plan($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        s = cyc + 2;
        run_seq(s, e);
        goto(s + 4);
        start = 1'b1;
        step();
        start = 1'b0;
        goto(e);
        start = 1'b1;
        set_plan(0, 0, 0, 0);
        model(e + 1, e2);
        step();
        step();
        start = 1'b0;
        goto(e2 + 3);

`ifdef INIT_SEQ_DELAY_CMD_EN
        fill_rom(1'b1);
        set_plan(0, 0, 1, 0);
        run_seq(cyc + 2, e);
        goto(e + 3);
`endif

        for (int k = 0; k < 4; k++) begin
            fill_rom(1'b0);
            set_plan($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
            run_seq(cyc + 1 + $urandom_range(1, 3), e);
            goto(e + 3);
        end

        goto(cyc + 5);
        fin = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its end, %0d miscompares so far", miscompares);
        $fatal(1);
    end

endmodule
